// File: rtl/axis_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rx_pkg
//  Description : Shared types and constants for the power-of-3 stream receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } rx_state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          ERR_CNT_W  = 16;
    localparam int          BEAT_CNT_W = 32;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sync_fifo
//  Description : Single-clock first-word fall-through FIFO; head reads 0 when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_pow3_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pow3_receiver
//  Description : AXI4-Stream slave checking beats against 3^n, buffering them
//                in a FIFO. Define AXIS_RX_THROTTLE_EN for LFSR backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pow3_receiver
    import axis_rx_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int HALT_ON_ERR = 0
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_aresetn,
    input  logic                    enable,
    input  logic [DATA_SIZE-1:0]    s00_axis_tdata,
    input  logic [DATA_SIZE/8-1:0]  s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    input  logic                    rd_en,
    output logic [DATA_SIZE-1:0]    rd_data,
    output logic                    rd_valid,
    output logic [BEAT_CNT_W-1:0]   beat_count,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic                    err_flag,
    output logic [DATA_SIZE-1:0]    first_err_data,
    output logic [15:0]             last_count
);

    rx_state_t                   state;
    rx_state_t                   state_next;
    logic [DATA_SIZE-1:0]        expected;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
    logic [DATA_SIZE/8-1:0]      tstrb_unused;
    logic                        throttle_ok;
    logic                        accept;
    logic                        mismatch;

`ifdef AXIS_RX_THROTTLE_EN
    logic [15:0] lfsr;

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign throttle_ok = lfsr[0];
`else
    assign throttle_ok = 1'b1;
`endif

    assign accept   = s00_axis_tvalid && s00_axis_tready;
    assign mismatch = accept && (s00_axis_tdata != expected);
    assign rd_valid = !fifo_empty;

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready depends only on registered state and FIFO occupancy
    always_comb begin
        state_next      = state;
        s00_axis_tready = (state == RUN) && !fifo_full && throttle_ok;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable)                           state_next = IDLE;
                else if ((HALT_ON_ERR != 0) && mismatch) state_next = HALT;
            end
            HALT: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Expected value advances on every accepted beat, matching or not
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            expected       <= DATA_SIZE'(1);
            beat_count     <= '0;
            last_count     <= '0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_data <= '0;
            tstrb_unused   <= '0;
        end else begin
            if (accept) begin
                expected     <= expected + {expected[DATA_SIZE-2:0], 1'b0};
                beat_count   <= beat_count + 1'b1;
                tstrb_unused <= s00_axis_tstrb;
                if (s00_axis_tlast) begin
                    last_count <= last_count + 1'b1;
                end
            end
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
                if (!err_flag) begin
                    first_err_data <= s00_axis_tdata;
                end
            end
        end
    end

    axis_sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (s00_axis_aclk),
        .rst_n     (s00_axis_aresetn),
        .push      (accept),
        .push_data (s00_axis_tdata),
        .pop       (rd_en),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rd_data),
        .count     (fifo_count_unused)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_pow3_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pow3_receiver
//  Description : Directed self-checking bench for axis_pow3_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pow3_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rstn, en, tvalid, tlast, tready, rd_en, rd_valid, err_flag;
    logic [31:0] tdata, rd_data, beat_count, first_err;
    logic [3:0]  tstrb;
    logic [15:0] err_count, last_count;

    // 8-bit instance with halt-on-error
    logic        b_rstn, b_en, b_tvalid, b_tlast, b_tready, b_rd_en, b_rd_valid, b_err_flag;
    logic [7:0]  b_tdata, b_rd_data, b_first_err;
    logic [0:0]  b_tstrb;
    logic [31:0] b_beat_count;
    logic [15:0] b_err_count, b_last_count;

    axis_pow3_receiver #(.DATA_SIZE(32), .FIFO_DEPTH(8), .HALT_ON_ERR(0)) dut_a (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rstn), .enable(en),
        .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid),
        .s00_axis_tlast(tlast), .s00_axis_tready(tready), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .beat_count(beat_count),
        .err_count(err_count), .err_flag(err_flag), .first_err_data(first_err),
        .last_count(last_count)
    );

    axis_pow3_receiver #(.DATA_SIZE(8), .FIFO_DEPTH(8), .HALT_ON_ERR(1)) dut_b (
        .s00_axis_aclk(clk), .s00_axis_aresetn(b_rstn), .enable(b_en),
        .s00_axis_tdata(b_tdata), .s00_axis_tstrb(b_tstrb), .s00_axis_tvalid(b_tvalid),
        .s00_axis_tlast(b_tlast), .s00_axis_tready(b_tready), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .beat_count(b_beat_count),
        .err_count(b_err_count), .err_flag(b_err_flag), .first_err_data(b_first_err),
        .last_count(b_last_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          exp_err;
    } vec_t;

    vec_t v1[10];
    vec_t v2[8];
    logic [7:0] v8[7];

    int checks = 0;
    int errors = 0;
    int exp_beats;
    int exp_lasts;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic acc_a(input logic [31:0] d, input logic l);
        int n = 0;
        tdata = d; tlast = l; tvalid = 1'b1;
        while (!tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            checks++; errors++;
            $display("FAIL acc_a_timeout: tready=%0d, expected 1", tready);
            tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic acc_b(input logic [7:0] d);
        int n = 0;
        b_tdata = d; b_tvalid = 1'b1;
        while (!b_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_tready) begin
            checks++; errors++;
            $display("FAIL acc_b_timeout: tready=%0d, expected 1", b_tready);
            b_tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        b_tvalid = 1'b0;
    endtask

    task automatic reset_a();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_beats = 0;
        exp_lasts = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pw;

        v1[0] = '{32'd1,     1'b0, 0}; v1[1] = '{32'd3,     1'b0, 0};
        v1[2] = '{32'd9,     1'b0, 0}; v1[3] = '{32'd27,    1'b1, 0};
        v1[4] = '{32'd81,    1'b0, 0}; v1[5] = '{32'd243,   1'b0, 0};
        v1[6] = '{32'd729,   1'b0, 0}; v1[7] = '{32'd2187,  1'b1, 0};
        v1[8] = '{32'd6561,  1'b0, 0}; v1[9] = '{32'd19683, 1'b1, 0};

        v2[0] = '{32'd1,   1'b0, 0}; v2[1] = '{32'd3,    1'b0, 0};
        v2[2] = '{32'd9,   1'b0, 0}; v2[3] = '{32'd28,   1'b1, 1};
        v2[4] = '{32'd81,  1'b0, 1}; v2[5] = '{32'd243,  1'b0, 1};
        v2[6] = '{32'd700, 1'b0, 2}; v2[7] = '{32'd2187, 1'b1, 2};

        v8[0] = 8'd1;  v8[1] = 8'd3;  v8[2] = 8'd9; v8[3] = 8'd27;
        v8[4] = 8'd81; v8[5] = 8'd243; v8[6] = 8'd217;

        rstn = 1'b0; en = 1'b0; tdata = '0; tstrb = 4'hF; tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0;
        b_rstn = 1'b0; b_en = 1'b0; b_tdata = '0; b_tstrb = 1'b1; b_tvalid = 1'b0; b_tlast = 1'b0; b_rd_en = 1'b0;
        exp_beats = 0; exp_lasts = 0;
        repeat (3) @(negedge clk);

        chk("rst_tready", tready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_beat_count", beat_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_first_err", first_err, 0);
        chk("rst_last_count", last_count, 0);

        rstn = 1'b1;
        @(negedge clk);
        chk("idle_tready", tready, 0);
        en = 1'b1; rd_en = 1'b1;
        @(negedge clk);

        // Ten clean beats with the reader popping continuously
        for (int i = 0; i < 10; i++) begin
            acc_a(v1[i].data, v1[i].last);
            exp_beats++;
            if (v1[i].last) exp_lasts++;
            chk("t1_rd_valid", rd_valid, 1);
            chk("t1_rd_data", rd_data, v1[i].data);
            chk("t1_err_count", err_count, v1[i].exp_err);
            chk("t1_beat_count", beat_count, exp_beats);
        end
        chk("t1_last_count", last_count, exp_lasts);
        chk("t1_err_flag", err_flag, 0);

        // Corrupted beats: one error each, first_err_data holds the first
        reset_a();
        for (int i = 0; i < 8; i++) begin
            acc_a(v2[i].data, v2[i].last);
            exp_beats++;
            if (v2[i].last) exp_lasts++;
            chk("t2_rd_data", rd_data, v2[i].data);
            chk("t2_err_count", err_count, v2[i].exp_err);
            chk("t2_beat_count", beat_count, exp_beats);
        end
        chk("t2_err_flag", err_flag, 1);
        chk("t2_first_err", first_err, 28);
        chk("t2_last_count", last_count, exp_lasts);

        // Backpressure: FIFO fills, one pop re-opens tready a cycle later
        rd_en = 1'b0;
        reset_a();
        chk("t3_rst_err_flag", err_flag, 0);
        chk("t3_rst_first_err", first_err, 0);
        pw = 32'd1;
        for (int i = 0; i < 8; i++) begin
            acc_a(pw, 1'b0);
            pw = pw * 3;
        end
        chk("t3_full_tready", tready, 0);
        chk("t3_full_head", rd_data, 1);
        chk("t3_full_beats", beat_count, 8);
        tdata = pw; tvalid = 1'b1;
        @(negedge clk);
        chk("t3_full_tready2", tready, 0);
        rd_en = 1'b1;
        chk("t3_pop_cycle_tready", tready, 0);
        @(negedge clk);
        rd_en = 1'b0;
        chk("t3_after_pop_tready", tready, 1);
        @(negedge clk);
        tvalid = 1'b0;
        chk("t3_ninth_beats", beat_count, 9);
        chk("t3_ninth_head", rd_data, 3);
        rd_en = 1'b1;
        pw = 32'd3;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_valid", rd_valid, 1);
            chk("t3_drain_data", rd_data, pw);
            @(negedge clk);
            pw = pw * 3;
        end
        rd_en = 1'b0;
        chk("t3_empty_valid", rd_valid, 0);
        chk("t3_empty_data", rd_data, 0);
        chk("t3_err_count", err_count, 0);

        // Reset with three buffered entries and a beat in flight
        reset_a();
        acc_a(32'd1, 1'b1);
        acc_a(32'd3, 1'b0);
        acc_a(32'd9, 1'b0);
        chk("t4_pre_valid", rd_valid, 1);
        tdata = 32'd27; tvalid = 1'b1; rstn = 1'b0;
        @(negedge clk);
        chk("t4_rst_valid", rd_valid, 0);
        chk("t4_rst_data", rd_data, 0);
        chk("t4_rst_beats", beat_count, 0);
        chk("t4_rst_lasts", last_count, 0);
        chk("t4_rst_tready", tready, 0);
        rstn = 1'b1; tvalid = 1'b0;
        @(negedge clk);
        acc_a(32'd1, 1'b0);
        chk("t4_restart_err", err_count, 0);
        chk("t4_restart_beats", beat_count, 1);
        chk("t4_restart_data", rd_data, 1);

        // Halt-on-error instance: mismatch on beat 2, then resume expecting 9
        b_en = 1'b1; b_rd_en = 1'b1; b_rstn = 1'b1;
        @(negedge clk);
        acc_b(8'd1);
        acc_b(8'd4);
        chk("b_halt_err", b_err_count, 1);
        chk("b_halt_first", b_first_err, 4);
        chk("b_halt_tready", b_tready, 0);
        @(negedge clk);
        chk("b_halt_tready2", b_tready, 0);
        b_en = 1'b0;
        @(negedge clk);
        chk("b_idle_tready", b_tready, 0);
        b_en = 1'b1;
        @(negedge clk);
        chk("b_resume_tready", b_tready, 1);
        acc_b(8'd9);
        chk("b_resume9_err", b_err_count, 1);
        acc_b(8'd27);
        chk("b_resume27_err", b_err_count, 1);
        chk("b_resume_beats", b_beat_count, 4);

        // 8-bit wrap of the expected sequence
        b_rstn = 1'b0;
        @(negedge clk);
        b_rstn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            acc_b(v8[i]);
            chk("b8_rd_data", b_rd_data, v8[i]);
        end
        chk("b8_err_count", b_err_count, 0);
        chk("b8_err_flag", b_err_flag, 0);
        chk("b8_beats", b_beat_count, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_pow3_receiver.md
Name: axis_pow3_receiver

Overview:
- AXI4-Stream slave that consumes the power-of-3 stream from the team's generator.
- Each accepted beat is checked against an internally generated expected value, 3^n mod 2^DATA_SIZE.
- Accepted data is buffered in a small FIFO that a downstream reader drains.
- Beat and error statistics are exported for the verification harness and status registers.

Parameters:
- DATA_SIZE, 32: tdata width in bits; multiple of 8.
- FIFO_DEPTH, 8: buffer entries; power of 2, at least 2.
- HALT_ON_ERR, 0: 1 means the first mismatch moves the block to HALT and stops acceptance.

Ports:
- s00_axis_aclk  in  1  clock.
- s00_axis_aresetn  in  1  synchronous active-low reset.
- enable  in  1  allows acceptance when high.
- s00_axis_tdata  in  DATA_SIZE  stream data.
- s00_axis_tstrb  in  DATA_SIZE/8  byte strobes; captured, not checked.
- s00_axis_tvalid  in  1  beat valid.
- s00_axis_tlast  in  1  end-of-packet marker.
- s00_axis_tready  out  1  receiver ready.
- rd_en  in  1  pop request from the downstream reader.
- rd_data  out  DATA_SIZE  FIFO head.
- rd_valid  out  1  FIFO non-empty.
- beat_count  out  32  accepted beats; wraps.
- err_count  out  16  mismatches; saturates at 16'hFFFF.
- err_flag  out  1  sticky mismatch flag.
- first_err_data  out  DATA_SIZE  tdata of the first mismatching beat.
- last_count  out  16  beats accepted with tlast=1; wraps.

Behaviour:
- Reset (s00_axis_aresetn low at clock edge):
  - state=IDLE; expected=1; FIFO empty.
  - tready=0, rd_valid=0, rd_data=0.
  - All counters 0; err_flag=0; first_err_data=0.
  - Reset mid-transfer discards FIFO contents and any in-flight beat.
- Handshake:
  - A beat is accepted on a clock edge where tvalid && tready.
  - tready = (state==RUN) && !fifo_full. It is derived from registered state and count only, never from tvalid.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0. The in-cycle acceptance still uses the current tready.
  - RUN -> HALT on a mismatching accepted beat, only when HALT_ON_ERR=1.
  - HALT -> IDLE only when enable=0.
  - tready=0 in IDLE and HALT.
- expected is preserved across IDLE/RUN transitions; only reset restores it to 1.
- Per accepted beat, in the same cycle:
  - compare tdata with expected.
  - expected <= (expected<<1) + expected, truncated to DATA_SIZE.
  - beat_count++.
  - tdata is pushed into the FIFO.
  - if tlast, last_count++.
- The expected value advances even on a mismatch, so a single corrupted beat produces exactly one error.
- On a mismatch:
  - err_count++ (saturating).
  - err_flag<=1.
  - first_err_data is captured only if err_flag was 0.
- FIFO:
  - First-word fall-through; rd_data is valid whenever rd_valid=1. rd_data is 0 when empty.
  - A pop occurs when rd_en && rd_valid.
  - rd_en while empty is ignored.
  - Push and pop in the same cycle keep the count unchanged.
  - When full, tready=0 even if a pop occurs in the same cycle; tready rises the following cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: an accepted beat appears on rd_data (rd_valid=1) one cycle after acceptance if the FIFO was empty. The counters and err_flag update one cycle after acceptance.

Optional Feature:
- Macro: AXIS_RX_THROTTLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset to seed; advances every cycle) gates readiness.
  - tready = (state==RUN) && !fifo_full && lfsr[0].
  - Purpose: pseudo-random backpressure for exercising the generator's handshake.
- Undefined: no LFSR logic; tready follows the base rule.

Decomposition:
- Package axis_rx_pkg holds:
  - rx_state_t enum: IDLE, RUN, HALT.
  - LFSR_SEED and LFSR_TAPS constants.
  - ERR_CNT_W=16 and BEAT_CNT_W=32.
- One sub-module, axis_sync_fifo, parameterised by width and depth. It exposes push, pop, full, empty, head data and count.
- Checker, state machine and counters stay in the top module.

Test Plan:
- Reset, then enable=1, 10 beats of 1,3,9,…,19683 with tvalid=1 and rd_en=1 -> beat_count=10, err_count=0, err_flag=0, rd_data sequence matches.
- Beat 4 sent as 28 instead of 27, then correct values continue -> err_count=1, err_flag=1, first_err_data=28, beat 5 (81) passes.
- rd_en=0 with FIFO_DEPTH=8 streaming -> tready drops after 8 accepts. One pop -> tready=1 the next cycle, 9th beat accepted.
- HALT_ON_ERR=1 with a mismatch on beat 2 -> tready=0 from the next cycle. enable low then high -> RUN, and checking resumes expecting 9.
- DATA_SIZE=8, 7 beats -> the 6th expected value is 243 and the 7th is 729 mod 256 = 217. Both pass, err_count=0.
- Reset asserted with 3 entries in the FIFO -> rd_valid=0, counters 0. The next beat must be 1 to pass.
